rv32_mem_arbiter: RTL and testbench
===================================

// Module: rv32_mem_arbiter
//
// PURPOSE
//   Shares one single-ported synchronous memory between the rv32 core's
//   instruction-fetch port (IF) and load/store port (LS).
//   Sits between rv32_single_cycle_core and the unified instr/data RAM.
//   The core stalls on a missing grant.
//   Arbitration is LS-priority with a starvation guard for IF.
//   Read data is routed back to the requester that owns it.
//
// PARAMETERS
//   ADDR_W      32  byte-address width
//   DATA_W      32  data width; byte enables are DATA_W/8 bits wide
//   STREAK_MAX  4   max consecutive LS grants while IF waits (>=1)
//
// PORTS
//   clk        in   1         clock, all state updates on rising edge
//   reset      in   1         synchronous, active-high reset
//   if_req     in   1         IF read request; held with if_addr until if_gnt
//   if_addr    in   ADDR_W    IF read address
//   if_gnt     out  1         IF request accepted this cycle
//   if_rvalid  out  1         if_rdata valid (1 cycle after if_gnt)
//   if_rdata   out  DATA_W    IF read data
//   ls_req     in   1         LS request; held with all ls_* fields until ls_gnt
//   ls_we      in   1         1 = write, 0 = read
//   ls_be      in   DATA_W/8  LS byte enables (writes only)
//   ls_addr    in   ADDR_W    LS address
//   ls_wdata   in   DATA_W    LS write data
//   ls_gnt     out  1         LS request accepted this cycle
//   ls_rvalid  out  1         ls_rdata valid (1 cycle after read grant)
//   ls_rdata   out  DATA_W    LS read data
//   mem_en     out  1         memory access strobe
//   mem_we     out  1         memory write enable
//   mem_be     out  DATA_W/8  memory byte enables
//   mem_addr   out  ADDR_W    memory address
//   mem_wdata  out  DATA_W    memory write data
//   mem_rdata  in   DATA_W    read data, valid the cycle after mem_en & !mem_we
//
// BEHAVIOUR
//   Grants and mem_* are combinational from the requests and registered state.
//   - At most one grant per cycle.
//   - mem_en = if_gnt | ls_gnt.
//   - When idle: mem_en, mem_we and mem_be are 0; mem_addr and mem_wdata are 0.
//   Arbitration:
//   - LS wins when ls_req, unless (if_req && streak == STREAK_MAX), then IF wins.
//   - IF grant drives mem_we=0, mem_be=0, mem_wdata=0.
//   Streak counter (width clog2(STREAK_MAX+1)):
//   - +1 on an LS grant while if_req=1, saturating at STREAK_MAX.
//   - Cleared on an IF grant, or on any cycle with if_req=0.
//   Response tracker FSM (registered):
//   - States: RSP_NONE, RSP_IF, RSP_LS.
//   - Next state: RSP_IF on an IF grant; RSP_LS on an LS read grant;
//     otherwise RSP_NONE (LS writes also give RSP_NONE).
//   - In RSP_IF: if_rvalid=1, if_rdata=mem_rdata.
//   - In RSP_LS: ls_rvalid=1, ls_rdata=mem_rdata.
//   - Non-owner rdata is forced to 0; both rvalid are 0 in RSP_NONE.
//   - LS writes produce no rvalid.
//   Latency:
//   - Grant in cycle N, rvalid in N+1.
//   - Back-to-back grants are allowed every cycle, giving full throughput.
//   Reset (while reset=1):
//   - if_gnt, ls_gnt and mem_en are forced 0.
//   - The FSM goes to RSP_NONE and streak to 0.
//   - A read granted in the cycle before reset asserts produces no rvalid.
//   - Outputs are valid from the first cycle after reset deasserts.
//   Assertions: protocol violations (request fields changing while req=1 and
//   gnt=0) are flagged in simulation only, with no RTL recovery.
//
// TESTING
//   1 reset=1 for 2 cycles, both req=1 -> gnts=0, mem_en=0; first cycle after
//     reset deasserts -> ls_gnt=1.
//   2 IF alone, if_addr=0x100, mem_rdata=0x00000013 -> if_gnt same cycle,
//     mem_addr=0x100; next cycle if_rvalid=1, if_rdata=0x13, ls_rvalid=0.
//   3 Both req held for 12 cycles, STREAK_MAX=4 -> grant sequence
//     LS,LS,LS,LS,IF,LS,LS,LS,LS,IF,LS,LS.
//   4 LS write addr=0x200, be=4'b0011, wdata=0xDEADBEEF -> mem_we=1,
//     mem_be=0011, mem_wdata=0xDEADBEEF; no rvalid next cycle.
//   5 IF read 0x0 in cycle N, LS read 0x40 in N+1 (mem returns 0xA then 0xB)
//     -> if_rvalid/0xA at N+1, ls_rvalid/0xB at N+2.
//   6 IF read granted, reset=1 the following cycle -> if_rvalid stays 0; the
//     streak restarts at 0 after reset.

Source files
------------

// File: rtl/rv32_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_mem_arbiter
//  Description : Shares one single-ported synchronous RAM between the rv32
//                core's instruction-fetch (IF) and load/store (LS) ports.
//                LS has priority; a streak counter guarantees IF a slot
//                after STREAK_MAX consecutive LS grants. Read data is
//                steered back to whichever port owns the outstanding read.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STREAK_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    // instruction-fetch port
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    // load/store port
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [DATA_W/8-1:0] ls_be,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    // memory side
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int c_streak_w = $clog2(STREAK_MAX + 1);
    localparam logic [c_streak_w-1:0] c_streak_max = c_streak_w'(STREAK_MAX);

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_LS   = 2'd2
    } rsp_t;

    rsp_t                  r_rsp;
    rsp_t                  w_rsp_next;
    logic [c_streak_w-1:0] r_streak;
    logic [c_streak_w-1:0] w_streak_next;
    logic                  w_if_wins;

    // IF overrides LS priority once LS has had its full streak while IF waited
    assign w_if_wins = if_req && (r_streak == c_streak_max);

    // Grant selection and memory-side mux; everything idles to zero
    always_comb begin
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            if (ls_req && !w_if_wins) begin
                ls_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (ls_gnt) begin
            mem_we    = ls_we;
            mem_be    = ls_be;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
        end
        mem_en = if_gnt | ls_gnt;
    end

    // Next response owner and next streak count
    always_comb begin
        w_rsp_next    = RSP_NONE;
        w_streak_next = r_streak;
        if (if_gnt) begin
            w_rsp_next = RSP_IF;
        end else if (ls_gnt && !ls_we) begin
            w_rsp_next = RSP_LS;
        end
        if (!if_req || if_gnt) begin
            w_streak_next = '0;
        end else if (ls_gnt && (r_streak != c_streak_max)) begin
            w_streak_next = r_streak + 1'b1;
        end
    end

    // Response tracker and streak registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp    <= RSP_NONE;
            r_streak <= '0;
        end else begin
            r_rsp    <= w_rsp_next;
            r_streak <= w_streak_next;
        end
    end

    // Read-data steering; gated by reset so a read granted just before reset
    // never surfaces as a response
    always_comb begin
        if_rvalid = !reset && (r_rsp == RSP_IF);
        ls_rvalid = !reset && (r_rsp == RSP_LS);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        ls_rdata  = ls_rvalid ? mem_rdata : '0;
    end

`ifndef SYNTHESIS
    a_one_grant: assert property (@(posedge clk) !(if_gnt && ls_gnt));

    a_if_hold: assert property (@(posedge clk) disable iff (reset)
        (if_req && !if_gnt) ##1 if_req |-> $stable(if_addr));

    a_ls_hold: assert property (@(posedge clk) disable iff (reset)
        (ls_req && !ls_gnt) ##1 ls_req |-> $stable({ls_we, ls_be, ls_addr, ls_wdata}));
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv32_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32_mem_arbiter
//  Description : Directed self-checking bench for rv32_mem_arbiter.
//                Inputs change and outputs are sampled around the falling
//                clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    rv32_mem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STREAK_MAX (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_be     (ls_be),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout got=0x%08h exp=0x%08h", 32'd0, 32'd1);
        $fatal(1, "watchdog expired");
    end

    logic [11:0] seq_if;

    initial begin
        reset     = 1'b1;
        if_req    = 1'b1;
        if_addr   = 32'h10;
        ls_req    = 1'b1;
        ls_we     = 1'b0;
        ls_be     = 4'h0;
        ls_addr   = 32'h20;
        ls_wdata  = 32'h0;
        mem_rdata = 32'h0;
        seq_if    = 12'b0010_0001_0000;

        // 1: reset holds off both requesters for two cycles
        repeat (2) begin
            @(negedge clk); #1;
            chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
            chk("rst_ls_gnt", {31'd0, ls_gnt}, 32'd0);
            chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
            chk("rst_rvalid", {30'd0, if_rvalid, ls_rvalid}, 32'd0);
        end
        reset = 1'b0; #1;
        chk("post_rst_ls_gnt", {31'd0, ls_gnt}, 32'd1);
        chk("post_rst_if_gnt", {31'd0, if_gnt}, 32'd0);
        @(negedge clk);
        if_req = 1'b0; ls_req = 1'b0; mem_rdata = 32'h55; #1;
        chk("post_rst_ls_rvalid", {31'd0, ls_rvalid}, 32'd1);
        chk("post_rst_ls_rdata", ls_rdata, 32'h55);
        chk("idle_mem_en", {31'd0, mem_en}, 32'd0);
        chk("idle_mem_addr", mem_addr, 32'd0);

        // 2: IF alone
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100; #1;
        chk("if_gnt", {31'd0, if_gnt}, 32'd1);
        chk("if_mem_addr", mem_addr, 32'h100);
        chk("if_mem_en", {31'd0, mem_en}, 32'd1);
        chk("if_mem_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        if_req = 1'b0; mem_rdata = 32'h13; #1;
        chk("if_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("if_rdata", if_rdata, 32'h13);
        chk("if_ls_rvalid", {31'd0, ls_rvalid}, 32'd0);
        chk("if_ls_rdata", ls_rdata, 32'd0);

        // 3: both requesting for 12 cycles -> IF in slots 4 and 9
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0;
            if_addr = 32'h300; ls_addr = 32'h400; #1;
            chk($sformatf("streak_if_gnt_%0d", i), {31'd0, if_gnt}, {31'd0, seq_if[i]});
            chk($sformatf("streak_ls_gnt_%0d", i), {31'd0, ls_gnt}, {31'd0, !seq_if[i]});
        end
        @(negedge clk);
        if_req = 1'b0; ls_req = 1'b0; #1;
        chk("streak_last_ls_rvalid", {31'd0, ls_rvalid}, 32'd1);

        // 4: LS write
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b0011;
        ls_addr = 32'h200; ls_wdata = 32'hDEADBEEF; #1;
        chk("wr_ls_gnt", {31'd0, ls_gnt}, 32'd1);
        chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
        chk("wr_mem_be", {28'd0, mem_be}, 32'h3);
        chk("wr_mem_addr", mem_addr, 32'h200);
        chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        @(negedge clk);
        ls_req = 1'b0; ls_we = 1'b0; ls_be = 4'h0; ls_wdata = 32'h0; #1;
        chk("wr_no_rvalid", {30'd0, if_rvalid, ls_rvalid}, 32'd0);
        chk("wr_idle_mem_en", {31'd0, mem_en}, 32'd0);

        // 5: IF read then LS read back-to-back
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0; #1;
        chk("b2b_if_gnt", {31'd0, if_gnt}, 32'd1);
        @(negedge clk);
        if_req = 1'b0; ls_req = 1'b1; ls_addr = 32'h40; mem_rdata = 32'hA; #1;
        chk("b2b_ls_gnt", {31'd0, ls_gnt}, 32'd1);
        chk("b2b_ls_mem_addr", mem_addr, 32'h40);
        chk("b2b_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("b2b_if_rdata", if_rdata, 32'hA);
        @(negedge clk);
        ls_req = 1'b0; mem_rdata = 32'hB; #1;
        chk("b2b_ls_rvalid", {31'd0, ls_rvalid}, 32'd1);
        chk("b2b_ls_rdata", ls_rdata, 32'hB);
        chk("b2b_if_rvalid_off", {31'd0, if_rvalid}, 32'd0);
        chk("b2b_if_rdata_off", if_rdata, 32'd0);

        // 6a: IF read granted, reset next cycle -> no response
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h500; #1;
        chk("rstrd_if_gnt", {31'd0, if_gnt}, 32'd1);
        @(negedge clk);
        if_req = 1'b0; reset = 1'b1; mem_rdata = 32'h77; #1;
        chk("rstrd_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        chk("rstrd_if_rdata", if_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0; #1;
        chk("rstrd_after_rvalid", {31'd0, if_rvalid}, 32'd0);

        // 6b: build a streak of 3, reset, and confirm the streak restarts
        repeat (3) begin
            @(negedge clk);
            if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h600; ls_addr = 32'h700; #1;
            chk("pre_rst_ls_gnt", {31'd0, ls_gnt}, 32'd1);
        end
        @(negedge clk);
        reset = 1'b1; #1;
        chk("mid_rst_gnts", {30'd0, if_gnt, ls_gnt}, 32'd0);
        chk("mid_rst_mem_en", {31'd0, mem_en}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk($sformatf("restart_if_gnt_%0d", i), {31'd0, if_gnt}, {31'd0, (i == 4)});
            chk($sformatf("restart_ls_gnt_%0d", i), {31'd0, ls_gnt}, {31'd0, (i != 4)});
        end
        @(negedge clk);
        if_req = 1'b0; ls_req = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
